// File: rtl/ddp_pkg.sv
// Shared packet definitions for the datapath stages (copy stage, LR branch stage).
// The packet is a flat 38-bit word. Named field bounds keep every stage consistent.
package ddp_pkg;

    localparam int PKT_W    = 38;
    localparam int LR_BIT   = 19;
    localparam int TAG_HI   = 37;
    localparam int TAG_LO   = 27;
    localparam int DEST_HI  = 26;
    localparam int DEST_LO  = 20;
    localparam int FLAG_BIT = 18;
    localparam int DATA_W   = FLAG_BIT;

    typedef logic [PKT_W-1:0] packet_t;

    typedef struct packed {
        logic [TAG_HI-TAG_LO:0]   tag;
        logic [DEST_HI-DEST_LO:0] dest;
        logic                     lr;
        logic                     flag;
        logic [DATA_W-1:0]        data;
    } packet_fields_t;

    function automatic logic pkt_side(input packet_t p);
        return p[LR_BIT];
    endfunction

    function automatic logic [DEST_HI-DEST_LO:0] pkt_dest(input packet_t p);
        return p[DEST_HI:DEST_LO];
    endfunction

    function automatic logic [TAG_HI-TAG_LO:0] pkt_tag(input packet_t p);
        return p[TAG_HI:TAG_LO];
    endfunction

    function automatic logic pkt_flag(input packet_t p);
        return p[FLAG_BIT];
    endfunction

    function automatic packet_fields_t pkt_unpack(input packet_t p);
        return packet_fields_t'(p);
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// One side of the LR branch stage: a small FIFO with wrap-bit pointers and a
// counter of packets handed to the downstream consumer.
module branch_fifo #(
    parameter int PKT_W = 38,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [PKT_W-1:0] wr_data_i,
    input  logic             rd_ack_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [PKT_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PKT_W-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic do_write;
    logic do_read;

    // Equal index with differing wrap bits means the writer has lapped the reader.
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_write = wr_en_i & ~full;
    assign do_read  = rd_ack_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
        end
    end

    assign full_o    = full;
    assign valid_o   = ~empty;
    assign rd_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/lr_branch_stage.sv
// LR branch stage: steers each packet from the copy stage to a left or right
// FIFO by its LR flag, so a stalled side does not block the other side.
module lr_branch_stage
    import ddp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             MR_N,
    input  logic             Send_in,
    input  logic [PKT_W-1:0] PACKET_IN,
    output logic             Ack_out,
    output logic             Send_out_L,
    output logic [PKT_W-1:0] PACKET_OUT_L,
    input  logic             Ack_in_L,
    output logic             Send_out_R,
    output logic [PKT_W-1:0] PACKET_OUT_R,
    input  logic             Ack_in_R,
    output logic [CNT_W-1:0] CNT_L,
    output logic [CNT_W-1:0] CNT_R
);

    logic side;
    logic full_l;
    logic full_r;
    logic side_full;
    logic wr_l;
    logic wr_r;

    assign side      = pkt_side(PACKET_IN);
    assign side_full = side ? full_r : full_l;

    // Gated by MR_N so no acknowledge is offered while the stage is held in reset.
    assign Ack_out = Send_in & MR_N & ~side_full;
    assign wr_l    = Ack_out & ~side;
    assign wr_r    = Ack_out & side;

    branch_fifo #(
        .PKT_W (PKT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo_l (
        .clk_i     (CLK),
        .rst_ni    (MR_N),
        .wr_en_i   (wr_l),
        .wr_data_i (PACKET_IN),
        .rd_ack_i  (Ack_in_L),
        .full_o    (full_l),
        .valid_o   (Send_out_L),
        .rd_data_o (PACKET_OUT_L),
        .cnt_o     (CNT_L)
    );

    branch_fifo #(
        .PKT_W (PKT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo_r (
        .clk_i     (CLK),
        .rst_ni    (MR_N),
        .wr_en_i   (wr_r),
        .wr_data_i (PACKET_IN),
        .rd_ack_i  (Ack_in_R),
        .full_o    (full_r),
        .valid_o   (Send_out_R),
        .rd_data_o (PACKET_OUT_R),
        .cnt_o     (CNT_R)
    );

endmodule

// File: tb/tb_lr_branch_stage.sv
// Directed testbench for lr_branch_stage: steering, per-side backpressure,
// independence of sides, counter wrap and asynchronous reset.
module tb_lr_branch_stage;

    logic        CLK = 1'b0;
    logic        MR_N;
    logic        Send_in;
    logic [37:0] PACKET_IN;
    logic        Ack_out;
    logic        Send_out_L;
    logic [37:0] PACKET_OUT_L;
    logic        Ack_in_L;
    logic        Send_out_R;
    logic [37:0] PACKET_OUT_R;
    logic        Ack_in_R;
    logic [15:0] CNT_L;
    logic [15:0] CNT_R;

    int assertCount = 0;
    int failCount   = 0;

    lr_branch_stage dut (
        .CLK          (CLK),
        .MR_N         (MR_N),
        .Send_in      (Send_in),
        .PACKET_IN    (PACKET_IN),
        .Ack_out      (Ack_out),
        .Send_out_L   (Send_out_L),
        .PACKET_OUT_L (PACKET_OUT_L),
        .Ack_in_L     (Ack_in_L),
        .Send_out_R   (Send_out_R),
        .PACKET_OUT_R (PACKET_OUT_R),
        .Ack_in_R     (Ack_in_R),
        .CNT_L        (CNT_L),
        .CNT_R        (CNT_R)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        MR_N      = 1'b0;
        Send_in   = 1'b0;
        PACKET_IN = '0;
        Ack_in_L  = 1'b0;
        Ack_in_R  = 1'b0;
        tick();
        MR_N = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        MR_N      = 1'b0;
        Send_in   = 1'b1;
        PACKET_IN = 38'h0000000001;
        Ack_in_L  = 1'b0;
        Ack_in_R  = 1'b0;
        #1;
        assertCount++;
        if (Ack_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ack: got %b expected 0", Ack_out); end
        tick();
        tick();
        assertCount++;
        if ({Send_out_L, Send_out_R} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_send: got %b expected 00", {Send_out_L, Send_out_R}); end
        assertCount++;
        if ({PACKET_OUT_L, PACKET_OUT_R} !== '0) begin failCount++; $display("[TB] FAIL reset_packet: got %h %h expected 0 0", PACKET_OUT_L, PACKET_OUT_R); end
        assertCount++;
        if ({CNT_L, CNT_R} !== 32'h0) begin failCount++; $display("[TB] FAIL reset_cnt: got %h %h expected 0 0", CNT_L, CNT_R); end
        assertCount++;
        if (Ack_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ack_held: got %b expected 0", Ack_out); end
        MR_N = 1'b1;
        #1;
        assertCount++;
        if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL release_ack: got %b expected 1", Ack_out); end
        tick();
        Send_in = 1'b0;
        #1;
        assertCount++;
        if (Send_out_L !== 1'b1 || PACKET_OUT_L !== 38'h0000000001) begin failCount++; $display("[TB] FAIL release_first_pkt: got %b %h expected 1 0000000001", Send_out_L, PACKET_OUT_L); end
    endtask

    task automatic test_steering();
        reset_dut();
        Ack_in_L  = 1'b1;
        Ack_in_R  = 1'b1;
        Send_in   = 1'b1;
        PACKET_IN = 38'h0000080000;
        #1;
        assertCount++;
        if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL steer_ack_r: got %b expected 1", Ack_out); end
        tick();
        PACKET_IN = 38'h0000000001;
        #1;
        assertCount++;
        if (Send_out_R !== 1'b1 || PACKET_OUT_R !== 38'h0000080000 || Send_out_L !== 1'b0) begin failCount++; $display("[TB] FAIL steer_r_out: got %b %h L=%b expected 1 0000080000 L=0", Send_out_R, PACKET_OUT_R, Send_out_L); end
        assertCount++;
        if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL steer_ack_l: got %b expected 1", Ack_out); end
        tick();
        Send_in = 1'b0;
        #1;
        assertCount++;
        if (Send_out_L !== 1'b1 || PACKET_OUT_L !== 38'h0000000001 || Send_out_R !== 1'b0) begin failCount++; $display("[TB] FAIL steer_l_out: got %b %h R=%b expected 1 0000000001 R=0", Send_out_L, PACKET_OUT_L, Send_out_R); end
        tick();
        assertCount++;
        if (CNT_L !== 16'd1 || CNT_R !== 16'd1 || Send_out_L !== 1'b0) begin failCount++; $display("[TB] FAIL steer_cnt: got L=%0d R=%0d vL=%b expected 1 1 0", CNT_L, CNT_R, Send_out_L); end
    endtask

    task automatic test_full_left();
        reset_dut();
        Send_in   = 1'b1;
        PACKET_IN = 38'h0000000011;
        #1;
        assertCount++;
        if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL full_ack1: got %b expected 1", Ack_out); end
        tick();
        PACKET_IN = 38'h0000000022;
        #1;
        assertCount++;
        if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL full_ack2: got %b expected 1", Ack_out); end
        tick();
        PACKET_IN = 38'h0000000033;
        #1;
        assertCount++;
        if (Ack_out !== 1'b0) begin failCount++; $display("[TB] FAIL full_ack3: got %b expected 0", Ack_out); end
        tick();
        Ack_in_L = 1'b1;
        #1;
        assertCount++;
        if (Ack_out !== 1'b0) begin failCount++; $display("[TB] FAIL full_same_cycle: got %b expected 0", Ack_out); end
        tick();
        Ack_in_L = 1'b0;
        #1;
        assertCount++;
        if (Ack_out !== 1'b1 || PACKET_OUT_L !== 38'h0000000022 || CNT_L !== 16'd1) begin failCount++; $display("[TB] FAIL full_next_cycle: got ack=%b %h cnt=%0d expected 1 0000000022 1", Ack_out, PACKET_OUT_L, CNT_L); end
        tick();
        PACKET_IN = 38'h0000000044;
        #1;
        assertCount++;
        if (Ack_out !== 1'b0) begin failCount++; $display("[TB] FAIL full_again: got %b expected 0", Ack_out); end
        Send_in  = 1'b0;
        Ack_in_L = 1'b1;
        tick();
        assertCount++;
        if (PACKET_OUT_L !== 38'h0000000033 || CNT_L !== 16'd2) begin failCount++; $display("[TB] FAIL full_third: got %h cnt=%0d expected 0000000033 2", PACKET_OUT_L, CNT_L); end
        tick();
        assertCount++;
        if (Send_out_L !== 1'b0 || CNT_L !== 16'd3) begin failCount++; $display("[TB] FAIL full_drain: got %b cnt=%0d expected 0 3", Send_out_L, CNT_L); end
    endtask

    task automatic test_independence();
        reset_dut();
        Send_in   = 1'b1;
        PACKET_IN = 38'h0000000101;
        tick();
        PACKET_IN = 38'h0000000202;
        tick();
        PACKET_IN = 38'h2ABCD81234;
        #1;
        assertCount++;
        if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL indep_ack_r: got %b expected 1", Ack_out); end
        tick();
        Send_in  = 1'b0;
        Ack_in_R = 1'b1;
        #1;
        assertCount++;
        if (Send_out_R !== 1'b1 || PACKET_OUT_R !== 38'h2ABCD81234) begin failCount++; $display("[TB] FAIL indep_r_out: got %b %h expected 1 2abcd81234", Send_out_R, PACKET_OUT_R); end
        tick();
        assertCount++;
        if (CNT_R !== 16'd1 || CNT_L !== 16'd0 || PACKET_OUT_L !== 38'h0000000101) begin failCount++; $display("[TB] FAIL indep_l_held: got R=%0d L=%0d %h expected 1 0 0000000101", CNT_R, CNT_L, PACKET_OUT_L); end
        Ack_in_L = 1'b1;
        tick();
        assertCount++;
        if (PACKET_OUT_L !== 38'h0000000202 || Send_out_L !== 1'b1) begin failCount++; $display("[TB] FAIL indep_l_order: got %b %h expected 1 0000000202", Send_out_L, PACKET_OUT_L); end
        tick();
        assertCount++;
        if (Send_out_L !== 1'b0 || CNT_L !== 16'd2) begin failCount++; $display("[TB] FAIL indep_l_drain: got %b cnt=%0d expected 0 2", Send_out_L, CNT_L); end
    endtask

    task automatic test_back_to_back();
        logic [37:0] pkts [4];
        pkts[0] = 38'h1000000001;
        pkts[1] = 38'h2000000002;
        pkts[2] = 38'h3000000003;
        pkts[3] = 38'h0400000004;
        reset_dut();
        Ack_in_L = 1'b1;
        Send_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PACKET_IN = pkts[i];
            #1;
            assertCount++;
            if (Ack_out !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_ack[%0d]: got %b expected 1", i, Ack_out); end
            tick();
            assertCount++;
            if (Send_out_L !== 1'b1 || PACKET_OUT_L !== pkts[i]) begin failCount++; $display("[TB] FAIL b2b_out[%0d]: got %b %h expected 1 %h", i, Send_out_L, PACKET_OUT_L, pkts[i]); end
        end
        Send_in   = 1'b0;
        PACKET_IN = '1;
        tick();
        tick();
        assertCount++;
        if (Send_out_L !== 1'b0 || Send_out_R !== 1'b0 || CNT_L !== 16'd4 || CNT_R !== 16'd0) begin failCount++; $display("[TB] FAIL b2b_idle: got %b %b L=%0d R=%0d expected 0 0 4 0", Send_out_L, Send_out_R, CNT_L, CNT_R); end
    endtask

    task automatic test_counter_wrap();
        reset_dut();
        Ack_in_L  = 1'b1;
        Send_in   = 1'b1;
        PACKET_IN = 38'h00000000AA;
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        Send_in = 1'b0;
        #1;
        assertCount++;
        if (CNT_L !== 16'hFFFF) begin failCount++; $display("[TB] FAIL wrap_pre: got %h expected ffff", CNT_L); end
        tick();
        assertCount++;
        if (CNT_L !== 16'h0000 || CNT_R !== 16'h0000 || Send_out_L !== 1'b0) begin failCount++; $display("[TB] FAIL wrap: got L=%h R=%h v=%b expected 0000 0000 0", CNT_L, CNT_R, Send_out_L); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        Ack_in_R  = 1'b1;
        Send_in   = 1'b1;
        PACKET_IN = 38'h0000080077;
        tick();
        Send_in = 1'b0;
        tick();
        Ack_in_R  = 1'b0;
        Send_in   = 1'b1;
        PACKET_IN = 38'h0000000055;
        tick();
        PACKET_IN = 38'h0000080066;
        tick();
        #1;
        assertCount++;
        if (Send_out_L !== 1'b1 || Send_out_R !== 1'b1 || CNT_R !== 16'd1) begin failCount++; $display("[TB] FAIL arst_pre: got %b %b cnt=%0d expected 1 1 1", Send_out_L, Send_out_R, CNT_R); end
        #1;
        MR_N = 1'b0;
        #1;
        assertCount++;
        if (Send_out_L !== 1'b0 || Send_out_R !== 1'b0 || PACKET_OUT_L !== '0 || PACKET_OUT_R !== '0) begin failCount++; $display("[TB] FAIL arst_clear: got %b %b %h %h expected 0 0 0 0", Send_out_L, Send_out_R, PACKET_OUT_L, PACKET_OUT_R); end
        assertCount++;
        if (CNT_R !== 16'd0 || Ack_out !== 1'b0) begin failCount++; $display("[TB] FAIL arst_cnt_ack: got cnt=%0d ack=%b expected 0 0", CNT_R, Ack_out); end
        Send_in = 1'b0;
        #2;
        MR_N = 1'b1;
        tick();
        tick();
        tick();
        assertCount++;
        if (Send_out_L !== 1'b0 || Send_out_R !== 1'b0) begin failCount++; $display("[TB] FAIL arst_stale: got %b %b expected 0 0", Send_out_L, Send_out_R); end
    endtask

    initial begin
        test_reset();
        test_steering();
        test_full_left();
        test_independence();
        test_back_to_back();
        test_counter_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
